// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Brief    : Pipeline MEM stage with data memory, byte/half/word loads and
//            stores, and the MEM/WB pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module memory_stage #(
    parameter int          DM_AW   = 10,
    parameter logic [31:0] DM_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC3,
    input  logic [31:0] Instr3,
    input  logic [31:0] Result3,
    input  logic [31:0] B3,
    input  logic [4:0]  WA3,
    input  logic [31:0] imm32_3,
    input  logic        ForwardRTM,
    input  logic [31:0] WD,
    output logic [31:0] PC4,
    output logic [31:0] Instr4,
    output logic [31:0] Result4,
    output logic [31:0] RD4,
    output logic [4:0]  WA4,
    output logic [31:0] imm32_4
);

    localparam int        c_DEPTH  = 2 ** DM_AW;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_SH  = 6'b101001;
    localparam logic [5:0] c_OP_SB  = 6'b101000;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_LH  = 6'b100001;
    localparam logic [5:0] c_OP_LHU = 6'b100101;
    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LBU = 6'b100100;

    logic [31:0]      mem_q [0:c_DEPTH-1];
    logic [31:0]      pc4_q, instr4_q, result4_q, rd4_q, imm4_q;
    logic [4:0]       wa4_q;
    logic [31:0]      pc4_d, instr4_d, result4_d, rd4_d, imm4_d;
    logic [4:0]       wa4_d;

    logic [5:0]       w_op;
    logic [DM_AW-1:0] w_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_sd;
    logic [15:0]      w_half;
    logic [7:0]       w_byte;
    logic             w_is_store;
    logic [31:0]      w_mem_wdata;

    // Truncating the shifted offset drops the high address bits, so accesses wrap.
    assign w_op   = Instr3[31:26];
    assign w_idx  = DM_AW'((Result3 - DM_BASE) >> 2);
    assign w_word = mem_q[w_idx];
    assign w_sd   = ForwardRTM ? WD : B3;
    assign w_half = Result3[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (Result3[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    // Store merge: untouched bytes keep the current word contents.
    always_comb begin
        w_is_store  = 1'b0;
        w_mem_wdata = w_word;
        case (w_op)
            c_OP_SW: begin
                w_is_store  = 1'b1;
                w_mem_wdata = w_sd;
            end
            c_OP_SH: begin
                w_is_store = 1'b1;
                if (Result3[1]) w_mem_wdata[31:16] = w_sd[15:0];
                else            w_mem_wdata[15:0]  = w_sd[15:0];
            end
            c_OP_SB: begin
                w_is_store = 1'b1;
                case (Result3[1:0])
                    2'd0: w_mem_wdata[7:0]   = w_sd[7:0];
                    2'd1: w_mem_wdata[15:8]  = w_sd[7:0];
                    2'd2: w_mem_wdata[23:16] = w_sd[7:0];
                    2'd3: w_mem_wdata[31:24] = w_sd[7:0];
                    default: w_mem_wdata = w_word;
                endcase
            end
            default: begin
                w_is_store  = 1'b0;
                w_mem_wdata = w_word;
            end
        endcase
    end

    always_comb begin
        pc4_d     = PC3;
        instr4_d  = Instr3;
        result4_d = Result3;
        wa4_d     = WA3;
        imm4_d    = imm32_3;
        case (w_op)
            c_OP_LW:  rd4_d = w_word;
            c_OP_LH:  rd4_d = {{16{w_half[15]}}, w_half};
            c_OP_LHU: rd4_d = {16'h0000, w_half};
            c_OP_LB:  rd4_d = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: rd4_d = {24'h000000, w_byte};
            default:  rd4_d = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc4_q     <= '0;
            instr4_q  <= '0;
            result4_q <= '0;
            rd4_q     <= '0;
            wa4_q     <= '0;
            imm4_q    <= '0;
        end else begin
            pc4_q     <= pc4_d;
            instr4_q  <= instr4_d;
            result4_q <= result4_d;
            rd4_q     <= rd4_d;
            wa4_q     <= wa4_d;
            imm4_q    <= imm4_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_is_store) begin
            mem_q[w_idx] <= w_mem_wdata;
        end
    end

    assign PC4     = pc4_q;
    assign Instr4  = instr4_q;
    assign Result4 = result4_q;
    assign RD4     = rd4_q;
    assign WA4     = wa4_q;
    assign imm32_4 = imm4_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Brief    : Directed and randomized checks of memory_stage against a
//            byte-addressed memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_stage;

    localparam logic [5:0] c_SW  = 6'b101011;
    localparam logic [5:0] c_SH  = 6'b101001;
    localparam logic [5:0] c_SB  = 6'b101000;
    localparam logic [5:0] c_LW  = 6'b100011;
    localparam logic [5:0] c_LH  = 6'b100001;
    localparam logic [5:0] c_LHU = 6'b100101;
    localparam logic [5:0] c_LB  = 6'b100000;
    localparam logic [5:0] c_LBU = 6'b100100;
    localparam logic [5:0] c_ALU = 6'b000000;
    localparam logic [5:0] c_ADI = 6'b001001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC3, Instr3, Result3, B3, imm32_3, WD;
    logic [4:0]  WA3;
    logic        ForwardRTM;
    logic [31:0] PC4, Instr4, Result4, RD4, imm32_4;
    logic [4:0]  WA4;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mb [0:4095];
    logic [31:0] got;

    memory_stage #(.DM_AW(10), .DM_BASE(32'h0)) dut (
        .clk(clk), .reset(reset),
        .PC3(PC3), .Instr3(Instr3), .Result3(Result3), .B3(B3),
        .WA3(WA3), .imm32_3(imm32_3), .ForwardRTM(ForwardRTM), .WD(WD),
        .PC4(PC4), .Instr4(Instr4), .Result4(Result4), .RD4(RD4),
        .WA4(WA4), .imm32_4(imm32_4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    endtask

    // One instruction through MEM; checks the MEM/WB register one edge later.
    task automatic step(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b3,
                        input logic fwd, input logic [31:0] wd, input logic [31:0] pc,
                        input logic [4:0] wa, output logic [31:0] rd_obs);
        logic [31:0] r, imm, sd, exp_rd, instr;
        int n, base;
        bit ld, st, sgn;
        r = $urandom(); imm = $urandom();
        instr = {op, r[25:0]};
        ld = 0; st = 0; sgn = 0; n = 1;
        case (op)
            c_SW:  begin st = 1; n = 4; end
            c_SH:  begin st = 1; n = 2; end
            c_SB:  begin st = 1; n = 1; end
            c_LW:  begin ld = 1; n = 4; end
            c_LH:  begin ld = 1; n = 2; sgn = 1; end
            c_LHU: begin ld = 1; n = 2; end
            c_LB:  begin ld = 1; n = 1; sgn = 1; end
            c_LBU: begin ld = 1; n = 1; end
            default: ;
        endcase
        base = int'(addr[11:0]) & ~(n - 1);
        exp_rd = 32'h0;
        if (ld) begin
            for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(mb[base + i]) << (8 * i));
            if (sgn && exp_rd[8 * n - 1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * n));
        end
        sd = fwd ? wd : b3;
        PC3 = pc; Instr3 = instr; Result3 = addr; B3 = b3; WA3 = wa;
        imm32_3 = imm; ForwardRTM = fwd; WD = wd;
        @(posedge clk); #1;
        if (st) for (int i = 0; i < n; i++) mb[base + i] = sd[8 * i +: 8];
        chk("PC4", PC4, pc);
        chk("Instr4", Instr4, instr);
        chk("Result4", Result4, addr);
        chk("WA4", {27'h0, WA4}, {27'h0, wa});
        chk("imm32_4", imm32_4, imm);
        chk("RD4", RD4, exp_rd);
        rd_obs = RD4;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_PC4"}, PC4, 32'h0);
        chk({tag, "_Instr4"}, Instr4, 32'h0);
        chk({tag, "_Result4"}, Result4, 32'h0);
        chk({tag, "_RD4"}, RD4, 32'h0);
        chk({tag, "_WA4"}, {27'h0, WA4}, 32'h0);
        chk({tag, "_imm32_4"}, imm32_4, 32'h0);
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] ra;
        ops = '{c_SW, c_SH, c_SB, c_LW, c_LH, c_LHU, c_LB, c_LBU, c_ALU, c_ADI};
        clear_model();
        reset = 1'b1;
        PC3 = 0; Instr3 = 0; Result3 = 0; B3 = 0; WA3 = 0; imm32_3 = 0; ForwardRTM = 0; WD = 0;
        #1;
        check_zero_outputs("reset");
        #10 reset = 1'b0;

        // Word store, then byte/half/word reads of it.
        step(c_SW,  32'h10, 32'h1234_5678, 0, 32'h0, 32'h1000, 5'd1, got);
        step(c_LB,  32'h13, 32'h0, 0, 32'h0, 32'h1004, 5'd2, got); chk("t2_lb",  got, 32'h0000_0012);
        step(c_LBU, 32'h13, 32'h0, 0, 32'h0, 32'h1008, 5'd3, got); chk("t2_lbu", got, 32'h0000_0012);
        step(c_LH,  32'h12, 32'h0, 0, 32'h0, 32'h100C, 5'd4, got); chk("t2_lh",  got, 32'h0000_1234);
        step(c_LW,  32'h10, 32'h0, 0, 32'h0, 32'h1010, 5'd5, got); chk("t2_lw",  got, 32'h1234_5678);

        // Partial stores merging into one word, with sign/zero extension.
        step(c_SW,  32'h20, 32'h0000_0000, 0, 32'h0, 32'h2000, 5'd0, got);
        step(c_SB,  32'h21, 32'h5555_55AB, 0, 32'h0, 32'h2004, 5'd0, got);
        step(c_SH,  32'h22, 32'h7777_8001, 0, 32'h0, 32'h2008, 5'd0, got);
        step(c_LW,  32'h20, 32'h0, 0, 32'h0, 32'h200C, 5'd6, got); chk("t3_lw",  got, 32'h8001_AB00);
        step(c_LH,  32'h22, 32'h0, 0, 32'h0, 32'h2010, 5'd6, got); chk("t3_lh",  got, 32'hFFFF_8001);
        step(c_LHU, 32'h22, 32'h0, 0, 32'h0, 32'h2014, 5'd6, got); chk("t3_lhu", got, 32'h0000_8001);
        step(c_LB,  32'h21, 32'h0, 0, 32'h0, 32'h2018, 5'd6, got); chk("t3_lb",  got, 32'hFFFF_FFAB);

        // Forwarded store data from WB.
        step(c_SW,  32'h30, 32'h1111_1111, 1, 32'hCAFE_BABE, 32'h2020, 5'd0, got);
        step(c_LW,  32'h30, 32'h0, 0, 32'h0, 32'h2024, 5'd7, got); chk("t4_fwd", got, 32'hCAFE_BABE);

        // Address wrap and forced word alignment.
        step(c_SW,  32'h1004, 32'hDEAD_BEEF, 0, 32'h0, 32'h2028, 5'd0, got);
        step(c_LW,  32'h0004, 32'h0, 0, 32'h0, 32'h202C, 5'd9, got); chk("t5_wrap", got, 32'hDEAD_BEEF);
        step(c_SW,  32'h0007, 32'h0BAD_F00D, 0, 32'h0, 32'h2030, 5'd0, got);
        step(c_LW,  32'h0004, 32'h0, 0, 32'h0, 32'h2034, 5'd9, got); chk("t5_align", got, 32'h0BAD_F00D);

        // Non-memory op passes through and leaves memory alone.
        step(c_ALU, 32'h55, 32'hFFFF_FFFF, 0, 32'h0, 32'h3004, 5'd8, got);
        chk("t6_rd", got, 32'h0);
        step(c_LW,  32'h10, 32'h0, 0, 32'h0, 32'h3008, 5'd1, got); chk("t6_mem", got, 32'h1234_5678);

        // Randomized traffic concentrated on a few words so reads hit writes.
        for (int k = 0; k < 400; k++) begin
            ra = $urandom() & 32'hFFFF_F03F;
            step(ops[$urandom_range(0, 9)], ra, $urandom(), 1'($urandom_range(0, 1)),
                 $urandom(), $urandom(), 5'($urandom_range(0, 31)), got);
        end

        // Reset pulsed between edges clears outputs at once and empties memory.
        #2 reset = 1'b1;
        #1 check_zero_outputs("midreset");
        clear_model();
        #2 reset = 1'b0;
        step(c_LW, 32'h0, 32'h0, 0, 32'h0, 32'h4000, 5'd3, got); chk("t1_lw0", got, 32'h0);
        step(c_LW, 32'h10, 32'h0, 0, 32'h0, 32'h4004, 5'd3, got); chk("t1_lw10", got, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
